// File: rtl/multimode_counter.sv
`default_nettype none
// ============================================================================
// multimode_counter - modulo counter, 4 parameter-selected moduli, deferred mode
// Revision: 1.0
// ============================================================================
module multimode_counter #(
  parameter int WIDTH = 4,
  parameter int MOD0  = 16,
  parameter int MOD1  = 10,
  parameter int MOD2  = 12,
  parameter int MOD3  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       active_mode,
  output logic             tc,
  output logic             co,
  output logic             mode_pend
);

  localparam int C_LIMIT = 2 ** WIDTH;

  if (MOD0 < 2 || MOD0 > C_LIMIT || MOD1 < 2 || MOD1 > C_LIMIT ||
      MOD2 < 2 || MOD2 > C_LIMIT || MOD3 < 2 || MOD3 > C_LIMIT) begin : g_bad_mod
    $fatal(1, "multimode_counter: every MODk must lie in 2 .. 2**WIDTH");
  end

  // Moduli are stored as M-1 so that M = 2**WIDTH still fits in WIDTH bits.
  localparam logic [WIDTH-1:0] C_MAX0 = WIDTH'(MOD0 - 1);
  localparam logic [WIDTH-1:0] C_MAX1 = WIDTH'(MOD1 - 1);
  localparam logic [WIDTH-1:0] C_MAX2 = WIDTH'(MOD2 - 1);
  localparam logic [WIDTH-1:0] C_MAX3 = WIDTH'(MOD3 - 1);
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  function automatic logic [WIDTH-1:0] max_of(input logic [1:0] sel);
    case (sel)
      2'd0:    max_of = C_MAX0;
      2'd1:    max_of = C_MAX1;
      2'd2:    max_of = C_MAX2;
      default: max_of = C_MAX3;
    endcase
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       amode_q, amode_d;
  logic [WIDTH-1:0] w_max_act;
  logic [WIDTH-1:0] w_max_req;
  logic [WIDTH-1:0] w_term;
  logic             w_tc;

  assign w_max_act = max_of(amode_q);
  assign w_max_req = max_of(mode);
  assign w_term    = up ? w_max_act : C_ZERO;
  assign w_tc      = (count_q == w_term);

  always_comb begin
    count_d = count_q;
    amode_d = amode_q;
    if (load) begin
      count_d = (load_val > w_max_req) ? w_max_req : load_val;
      amode_d = mode;
    end else if (en) begin
      if (w_tc) begin
        // Wrap start value uses the modulus of the mode taking effect now.
        count_d = up ? C_ZERO : w_max_req;
        amode_d = mode;
      end else begin
        count_d = up ? (count_q + C_ONE) : (count_q - C_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      amode_q <= 2'd0;
    end else begin
      count_q <= count_d;
      amode_q <= amode_d;
    end
  end

  assign q           = count_q;
  assign active_mode = amode_q;
  assign tc          = w_tc;
  assign co          = w_tc & en;
  assign mode_pend   = (mode != amode_q);

endmodule
`default_nettype wire

// File: doc/multimode_counter.md
# multimode_counter

Parametrised successor to the team's dual-mode counter. It is a modulo counter with four parameter-selected moduli, up/down direction, count enable, synchronous parallel load, and a terminal-count output for cascading. Mode changes are deferred to the next wrap boundary, so a running count is never cut short or driven out of range. It sits in the timing/sequencing datapath wherever a programmable divide-by-N or cycle counter is needed.

## Interface
- WIDTH, 4, counter width in bits
- MOD0, 16, modulus for mode 0; legal range 2 to 2^WIDTH
- MOD1, 10, modulus for mode 1; same legal range
- MOD2, 12, modulus for mode 2; same legal range
- MOD3, 6, modulus for mode 3; same legal range

- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-low
- en  input  1  count enable
- up  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load, highest synchronous priority
- load_val  input  WIDTH  load data
- mode  input  2  requested mode, selects MOD0..MOD3
- q  output  WIDTH  count value, registered
- active_mode  output  2  mode currently in force, registered
- tc  output  1  terminal count, combinational from q/active_mode/up
- co  output  1  cascade carry = tc & en
- mode_pend  output  1  high when mode != active_mode

## Operation
- M = MOD[active_mode].
- Terminal value T: M-1 when up=1, 0 when up=0.
- Start value S: 0 when up=1, M'-1 when up=0, where M' is the modulus of the mode taking effect at that edge.
- Reset (reset=0, any time, no clock needed): q=0, active_mode=0, so tc=1 if up=0 else 0, co=tc&en, mode_pend=(mode!=0).
- Each rising edge applies the first matching case:
  - load=1: q <= min(load_val, MOD[mode]-1) (clamped), active_mode <= mode. The en value is ignored.
  - en=1 and q==T: wrap. q <= S using the new mode, and active_mode <= mode as sampled at this edge.
  - en=1 and q!=T: q <= q+1 if up, else q-1. active_mode is unchanged.
  - en=0: hold q and active_mode.
- Invariant: q <= M-1 always. A mode change outside a wrap or load never applies to the current count.
- Direction may change at any cycle. T and S follow the current up value; there is no pending direction state.
- Arithmetic is WIDTH bits wide. With MODk = 2^WIDTH, the up wrap from 2^WIDTH-1 to 0 is exact and must not overflow into an incorrect comparison.
- Elaboration checks: fatal error if any MODk < 2 or MODk > 2^WIDTH.

## Timing
- q and active_mode update 1 cycle after the sampling edge.
- tc, co, and mode_pend are combinational from registered state plus the up, en, and mode inputs. There is no additional latency.
- tc is high for the whole cycle in which q==T. With en held at 1, co pulses for 1 cycle every M cycles.
- Mode-change latency: the request must be stable at the wrap edge. The new modulus applies from the first count after that wrap. load applies the new mode immediately.
- load and wrap in the same cycle: load wins. No wrap occurs and active_mode comes from mode.
- Asynchronous reset asserted mid-count: outputs go to their reset values immediately. On deassertion, counting resumes from 0 at the next enabled edge.

## Test plan
- Reset/hold: assert reset mid-count at q=7. Expect q=0 and active_mode=0 without a clock edge. With up=1 and en=0 over 5 edges, expect q held at 0 and tc=0.
- Mode 0 up count: en=1, up=1, mode=0 for 17 edges from reset. Expect q=0..15 then 0. Expect tc=co=1 only while q=15.
- Deferred mode change: in mode 0 at q=5, set mode=1. Expect mode_pend=1 and counting continuing to 15. At the wrap, expect q=0 and active_mode=1. Then expect count 0..9 with tc at 9, and mode_pend=0 after the wrap.
- Down count in mode 1: up=0, en=1. Expect q 9,8,...,0 with tc at 0. Expect a wrap to 9 (MOD1-1).
- Load clamp: mode=3 (MOD3=6), load=1, load_val=12, en=1. Expect q=5, active_mode=3, and no count that cycle. Next edge with up=1: wrap to 0.
- Load vs wrap collision: q=T with en=1, load=1, load_val=3, mode=2. Expect q=3, active_mode=2, no wrap, and tc=0 on the next cycle when up=1.
